// File: rtl/bram_arb_pkg.sv
// Shared definitions for the block-RAM round-robin arbiter.
package bram_arb_pkg;

    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 8;

    // Width of the round-robin pointer for a given requester count.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Index of the set bit in a one-hot vector; 0 when no bit is set.
    function automatic logic [2:0] onehot_to_idx(input logic [NUM_REQ_MAX-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ_MAX; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotate-and-find-first: picks the first valid requester at or after rr_ptr.
module rr_priority_pick
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    int idx;

    // Scan from the farthest slot back to rr_ptr so the nearest valid one wins.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
        grant_idx = PTR_W'(onehot_to_idx(NUM_REQ_MAX'(grant)));
    end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous block-RAM port among NUM_REQ
// single-word read/write requesters; routes read data back one cycle later.
module bram_rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_din,
    input  logic [DATA_WIDTH-1:0]         ram_dout
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    generate
        if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
            $error("bram_rr_arbiter: NUM_REQ must be within 2..8");
        end
    endgenerate

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] rsp_pend;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               xfer;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Gate grants and responses during reset; mux the granted command onto the RAM port.
    always_comb begin
        req_ready = rst_n ? grant : '0;
        xfer      = |(req_valid & req_ready);
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        if (xfer) begin
            ram_we   = req_we[grant_idx];
            ram_addr = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            ram_din  = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end
        // A read pending across the reset assertion is dropped, not delivered.
        rsp_valid = rst_n ? rsp_pend : '0;
        rsp_rdata = ram_dout;
    end

    // Advance the pointer past the winner and tag which requester owns next cycle's read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            rsp_pend <= '0;
        end else begin
            if (xfer) begin
                rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            rsp_pend <= (xfer && !req_we[grant_idx]) ? grant : '0;
        end
    end

endmodule

// File: doc/bram_rr_arbiter.md
# bram_rr_arbiter

Round-robin arbiter that shares one port of the synchronous dual-port block RAM among NUM_REQ requesters. Each requester issues single-word read or write commands with a valid/ready handshake. The arbiter multiplexes the granted command onto the RAM port and routes the registered read data back to the requester that issued the read. It sits between client logic and port A (or port B) of `bram_syn_dual_port`. The other RAM port is outside its control.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- ADDR_WIDTH, 10: RAM address width; must match the RAM instance.
- DATA_WIDTH, 8: RAM data width; must match the RAM instance.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_we  in  NUM_REQ  per-requester: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing.
- rsp_valid  out  NUM_REQ  one-cycle read-response strobe, one-hot or zero.
- rsp_rdata  out  DATA_WIDTH  read data; shared by all requesters, qualified by rsp_valid.
- ram_we  out  1  to RAM we_x.
- ram_addr  out  ADDR_WIDTH  to RAM addr_x.
- ram_din  out  DATA_WIDTH  to RAM din_x.
- ram_dout  in  DATA_WIDTH  from RAM dout_x.

## Operation
- State:
  - rr_ptr: $clog2(NUM_REQ) bits.
  - rsp_pend: NUM_REQ-bit one-hot register tagging the outstanding read.
- Arbitration (combinational each cycle):
  - Scan req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit i is granted: req_ready[i]=1. All other ready bits are 0.
- Issue: a command transfers when req_valid[i] && req_ready[i].
  - ram_we = req_we[i]
  - ram_addr = req_addr slice i
  - ram_din = req_wdata slice i
- Idle: with no valid requester, ram_we=0 and ram_addr/ram_din hold 0.
- Pointer update:
  - On transfer from i: rr_ptr <= (i+1) mod NUM_REQ. Wrap from NUM_REQ-1 to 0.
  - No transfer: rr_ptr holds.
- Response tag:
  - rsp_pend <= one-hot(i) when the transfer is a read; otherwise 0.
  - rsp_valid = rsp_pend; rsp_rdata = ram_dout.
- Writes produce no response.
- Requester rule: valid, we, addr and wdata are held stable until ready. The arbiter never withdraws a grant within the cycle it is given.
- Reset (rst_n low at a clock edge):
  - rr_ptr <= 0, rsp_pend <= 0.
  - While rst_n is low: req_ready=0, ram_we=0, rsp_valid=0.
- Reset mid-operation: a read issued in the cycle before reset is dropped. Its rsp_valid never asserts.

## Timing
- Grant latency: 0 cycles. A lone valid requester is granted in the same cycle.
- Read latency: read issued in cycle T; rsp_valid[i] and rsp_rdata valid in T+1 for exactly one cycle.
- Throughput: one command per cycle, back-to-back, across any mix of requesters.
- Write then read of the same address:
  - Write in T, read in T+1: the read returns the new data in T+2.
  - Read and write in the same cycle is impossible on one port.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- Port collisions: same-address accesses against the opposite RAM port are outside this block's guarantees.

## Structure
- Package bram_arb_pkg holds:
  - the NUM_REQ legality bound (2..8);
  - a localparam function for pointer width;
  - a one-hot-to-index function.
- Sub-module rr_priority_pick: purely combinational rotate-and-find-first. Inputs req_valid and rr_ptr; outputs grant one-hot and grant index.
- The top level holds the command mux, rr_ptr and rsp_pend registers, and reset gating.

## Test plan
- Reset: rst_n=0 for 2 cycles with all req_valid=1 -> req_ready=0, ram_we=0, rsp_valid=0. First grant after release goes to requester 0.
- Single read: requester 2 reads addr 0x05, RAM preloaded with 0xA5 -> ram_addr=0x05 in T. rsp_valid=4'b0100 and rsp_rdata=0xA5 in T+1.
- Round-robin: all four valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3. Each rsp_valid one-hot follows its read by one cycle.
- Wrap and skip: rr_ptr=3, only requesters 1 and 3 valid -> grant 3, then 1, then 3.
- Write-then-read: requester 0 writes 0x3C to 0x10, requester 1 reads 0x10 in the next cycle -> rsp_valid=4'b0010, rsp_rdata=0x3C. No rsp_valid for the write.
- Reset mid-read: requester 1 read in T, rst_n=0 in T+1 -> rsp_valid stays 0 and rr_ptr returns to 0.
